// File: rtl/rgb_pwm_pkg.sv
// Shared definitions for the RGB LED PWM controller: channel mode encodings.
package rgb_pwm_pkg;

    localparam int MODE_W = 2;

    typedef enum logic [MODE_W-1:0] {
        MODE_OFF     = 2'd0,
        MODE_STEADY  = 2'd1,
        MODE_BLINK   = 2'd2,
        MODE_BREATHE = 2'd3
    } mode_t;

endpackage

// File: rtl/rgb_pwm_ch.sv
// One PWM channel: pending/active configuration, breathe ramp, duty compare
// and the registered PWM output.
module rgb_pwm_ch
    import rgb_pwm_pkg::*;
#(
    parameter int PWM_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 wrap,
    input  logic                 blink_on,
    input  logic                 we,
    input  logic [PWM_WIDTH-1:0] cnt,
    input  logic [PWM_WIDTH-1:0] cfg_duty,
    input  logic [MODE_W-1:0]    cfg_mode,
    output logic                 pwm,
    output logic                 active_on
);

    logic [PWM_WIDTH-1:0] pend_duty_r;
    mode_t                pend_mode_r;
    logic [PWM_WIDTH-1:0] act_duty_r;
    mode_t                act_mode_r;
    logic [PWM_WIDTH-1:0] ramp_r;
    logic                 dir_down_r;
    logic                 pwm_r;

    logic [PWM_WIDTH-1:0] next_duty_s;
    mode_t                next_mode_s;
    logic [PWM_WIDTH-1:0] ramp_next_s;
    logic                 dir_next_s;
    logic [PWM_WIDTH-1:0] ramp_inc_s;
    logic [PWM_WIDTH-1:0] ramp_dec_s;
    logic [PWM_WIDTH-1:0] eff_duty_s;

    // A write landing on the wrap cycle bypasses the pending registers.
    always_comb begin
        next_duty_s = pend_duty_r;
        next_mode_s = pend_mode_r;
        if (we) begin
            next_duty_s = cfg_duty;
            next_mode_s = mode_t'(cfg_mode);
        end else begin
            next_duty_s = pend_duty_r;
            next_mode_s = pend_mode_r;
        end
    end

    assign ramp_inc_s = ramp_r + PWM_WIDTH'(1);
    assign ramp_dec_s = ramp_r - PWM_WIDTH'(1);

    // Breathe ramp step, evaluated against the values that become active at this wrap.
    always_comb begin
        ramp_next_s = ramp_r;
        dir_next_s  = dir_down_r;
        if (next_mode_s != MODE_BREATHE || next_duty_s == '0) begin
            ramp_next_s = '0;
            dir_next_s  = 1'b0;
        end else if (ramp_r > next_duty_s) begin
            ramp_next_s = next_duty_s;
            dir_next_s  = 1'b1;
        end else if (!dir_down_r) begin
            if (ramp_r < next_duty_s) begin
                ramp_next_s = ramp_inc_s;
                dir_next_s  = (ramp_inc_s == next_duty_s);
            end else begin
                ramp_next_s = ramp_dec_s;
                dir_next_s  = 1'b1;
            end
        end else begin
            if (ramp_r != '0) begin
                ramp_next_s = ramp_dec_s;
                dir_next_s  = (ramp_dec_s != '0);
            end else begin
                ramp_next_s = ramp_inc_s;
                dir_next_s  = (ramp_inc_s == next_duty_s);
            end
        end
    end

    // Effective duty per active mode.
    always_comb begin
        eff_duty_s = '0;
        case (act_mode_r)
            MODE_STEADY:  eff_duty_s = act_duty_r;
            MODE_BLINK:   eff_duty_s = blink_on ? act_duty_r : '0;
            MODE_BREATHE: eff_duty_s = ramp_r;
            default:      eff_duty_s = '0;
        endcase
    end

    // Configuration, ramp and output registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pend_duty_r <= '0;
            pend_mode_r <= MODE_OFF;
            act_duty_r  <= '0;
            act_mode_r  <= MODE_OFF;
            ramp_r      <= '0;
            dir_down_r  <= 1'b0;
            pwm_r       <= 1'b0;
        end else begin
            if (we) begin
                pend_duty_r <= cfg_duty;
                pend_mode_r <= mode_t'(cfg_mode);
            end
            if (wrap) begin
                act_duty_r <= next_duty_s;
                act_mode_r <= next_mode_s;
                ramp_r     <= ramp_next_s;
                dir_down_r <= dir_next_s;
            end
            pwm_r <= (cnt < eff_duty_s);
        end
    end

    assign pwm       = pwm_r;
    assign active_on = (act_mode_r != MODE_OFF);

endmodule

// File: rtl/rgb_pwm.sv
// RGB LED PWM controller: shared prescaler, PWM period counter and blink
// phase driving NUM_CH independently configured channels.
module rgb_pwm
    import rgb_pwm_pkg::*;
#(
    parameter int  NUM_CH         = 3,
    parameter int  PWM_WIDTH      = 8,
    parameter int  PRESCALE_WIDTH = 8,
    parameter int  BLINK_WIDTH    = 8,
    localparam int CH_W           = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [PRESCALE_WIDTH-1:0] prescale,
    input  logic                      cfg_we,
    input  logic [CH_W-1:0]           cfg_ch,
    input  logic [PWM_WIDTH-1:0]      cfg_duty,
    input  logic [MODE_W-1:0]         cfg_mode,
    input  logic [BLINK_WIDTH-1:0]    blink_half,
    output logic [NUM_CH-1:0]         pwm_out,
    output logic                      led_en,
    output logic                      period_start
);

    logic [PRESCALE_WIDTH-1:0] presc_r;
    logic [PWM_WIDTH-1:0]      pwm_cnt_r;
    logic [BLINK_WIDTH-1:0]    blink_cnt_r;
    logic                      blink_on_r;
    logic                      led_en_r;
    logic                      period_start_r;

    logic                      tick_s;
    logic                      wrap_s;
    logic [NUM_CH-1:0]         we_s;
    logic [NUM_CH-1:0]         active_on_s;
    logic [NUM_CH-1:0]         pwm_s;

    assign tick_s = (presc_r == prescale);
    assign wrap_s = tick_s && (pwm_cnt_r == '1);

    // Timebase: prescaler, period counter, blink phase and the shared status flops.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            presc_r        <= '0;
            pwm_cnt_r      <= '0;
            blink_cnt_r    <= '0;
            blink_on_r     <= 1'b1;
            led_en_r       <= 1'b0;
            period_start_r <= 1'b0;
        end else begin
            // >= so a prescale lowered below the running count restarts at once
            if (presc_r >= prescale) begin
                presc_r <= '0;
            end else begin
                presc_r <= presc_r + PRESCALE_WIDTH'(1);
            end
            if (tick_s) begin
                pwm_cnt_r <= pwm_cnt_r + PWM_WIDTH'(1);
            end
            if (wrap_s) begin
                if (blink_cnt_r >= blink_half) begin
                    blink_cnt_r <= '0;
                    blink_on_r  <= ~blink_on_r;
                end else begin
                    blink_cnt_r <= blink_cnt_r + BLINK_WIDTH'(1);
                end
            end
            period_start_r <= wrap_s;
            led_en_r       <= |active_on_s;
        end
    end

    genvar g;
    generate
        for (g = 0; g < NUM_CH; g++) begin : g_ch
            assign we_s[g] = cfg_we && (cfg_ch == CH_W'(g));

            rgb_pwm_ch #(
                .PWM_WIDTH (PWM_WIDTH)
            ) u_ch (
                .clk       (clk),
                .reset_n   (reset_n),
                .wrap      (wrap_s),
                .blink_on  (blink_on_r),
                .we        (we_s[g]),
                .cnt       (pwm_cnt_r),
                .cfg_duty  (cfg_duty),
                .cfg_mode  (cfg_mode),
                .pwm       (pwm_s[g]),
                .active_on (active_on_s[g])
            );
        end
    endgenerate

    assign pwm_out      = pwm_s;
    assign led_en       = led_en_r;
    assign period_start = period_start_r;

endmodule

// File: tb/tb_rgb_pwm.sv
// Scoreboard bench for rgb_pwm: expected per-period high counts are queued
// per scenario and compared against windows measured between period_start pulses.
module tb_rgb_pwm;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] prescale = 8'd0;
    logic       cfg_we = 1'b0;
    logic [1:0] cfg_ch = 2'd0;
    logic [7:0] cfg_duty = 8'd0;
    logic [1:0] cfg_mode = 2'd0;
    logic [7:0] blink_half = 8'd0;
    logic [2:0] pwm_out;
    logic       led_en;
    logic       period_start;

    int check_cnt = 0;
    int err_cnt = 0;

    rgb_pwm #(
        .NUM_CH(3), .PWM_WIDTH(8), .PRESCALE_WIDTH(8), .BLINK_WIDTH(8)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .prescale     (prescale),
        .cfg_we       (cfg_we),
        .cfg_ch       (cfg_ch),
        .cfg_duty     (cfg_duty),
        .cfg_mode     (cfg_mode),
        .blink_half   (blink_half),
        .pwm_out      (pwm_out),
        .led_en       (led_en),
        .period_start (period_start)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0][15:0] hi;
        logic [15:0]      len;
        logic             led_all;
        logic             led_any;
    } win_t;

    typedef struct packed {
        logic [2:0][15:0] hi;
        logic [15:0]      len;
        logic             chk_led;
    } exp_t;

    win_t obs_q[$];
    exp_t exp_q[$];
    win_t cur = '0;
    int   period_cnt = 0;

    // Window monitor: one entry per PWM period, closed at each period_start.
    always @(negedge clk) begin
        if (period_start === 1'b1) begin
            obs_q.push_back(cur);
            period_cnt = period_cnt + 1;
            cur.len = 16'd1;
            cur.led_all = (led_en === 1'b1);
            cur.led_any = (led_en === 1'b1);
            for (int c = 0; c < 3; c++) cur.hi[c] = (pwm_out[c] === 1'b1) ? 16'd1 : 16'd0;
        end else begin
            cur.len = cur.len + 16'd1;
            cur.led_all = cur.led_all & (led_en === 1'b1);
            cur.led_any = cur.led_any | (led_en === 1'b1);
            for (int c = 0; c < 3; c++) cur.hi[c] = cur.hi[c] + ((pwm_out[c] === 1'b1) ? 16'd1 : 16'd0);
        end
    end

    function automatic void push_exp(int h0, int h1, int h2, int len, bit chk_led);
        exp_t e;
        e.hi[0] = 16'(h0);
        e.hi[1] = 16'(h1);
        e.hi[2] = 16'(h2);
        e.len = 16'(len);
        e.chk_led = chk_led;
        exp_q.push_back(e);
    endfunction

    task automatic cfg_write(input int ch, input int duty, input int mode);
        #1;
        cfg_we = 1'b1;
        cfg_ch = 2'(ch);
        cfg_duty = 8'(duty);
        cfg_mode = 2'(mode);
        @(posedge clk);
        #1;
        cfg_we = 1'b0;
    endtask

    task automatic apply_reset();
        #1;
        cfg_we = 1'b0;
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    // Returns on the first posedge after a period_start, with both queues emptied.
    task automatic sync_period();
        int n0;
        int k;
        n0 = period_cnt;
        k = 0;
        while (period_cnt == n0 && k < 5000) begin
            @(posedge clk);
            k++;
        end
        if (period_cnt == n0) begin
            check_cnt++;
            err_cnt++;
            $display("FAIL sync_timeout: no period_start within %0d cycles", k);
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic wait_obs(output bit ok);
        int k;
        k = 0;
        while (obs_q.size() == 0 && k < 5000) begin
            @(posedge clk);
            k++;
        end
        ok = (obs_q.size() != 0);
    endtask

    task automatic test_reset();
        int k;
        repeat (3) @(posedge clk);
        #1;
        check_cnt++;
        if (pwm_out !== 3'b000) begin err_cnt++; $display("FAIL reset_pwm: got %b need 000", pwm_out); end
        check_cnt++;
        if (led_en !== 1'b0) begin err_cnt++; $display("FAIL reset_led_en: got %b need 0", led_en); end
        check_cnt++;
        if (period_start !== 1'b0) begin err_cnt++; $display("FAIL reset_period_start: got %b need 0", period_start); end
        reset_n = 1'b1;
        k = 0;
        while (k < 2000) begin
            @(posedge clk);
            #1;
            k++;
            if (period_start === 1'b1) break;
        end
        check_cnt++;
        if (k != 256) begin err_cnt++; $display("FAIL reset_first_wrap: got %0d cycles need 256", k); end
    endtask

    task automatic test_steady();
        bit ok;
        win_t o;
        exp_t e;
        prescale = 8'd0;
        cfg_write(0, 64, 1);
        sync_period();
        push_exp(64, 0, 0, 256, 1'b0);
        push_exp(64, 0, 0, 256, 1'b1);
        for (int i = 0; i < 2; i++) begin
            wait_obs(ok);
            check_cnt++;
            if (!ok) begin err_cnt++; $display("FAIL steady_timeout: no period %0d", i); end
            else begin
                o = obs_q.pop_front();
                e = exp_q.pop_front();
                for (int c = 0; c < 3; c++) begin
                    check_cnt++;
                    if (o.hi[c] !== e.hi[c]) begin err_cnt++; $display("FAIL steady_hi ch%0d p%0d: got %0d need %0d", c, i, o.hi[c], e.hi[c]); end
                end
                check_cnt++;
                if (o.len !== e.len) begin err_cnt++; $display("FAIL steady_len p%0d: got %0d need %0d", i, o.len, e.len); end
                if (e.chk_led) begin
                    check_cnt++;
                    if (o.led_all !== 1'b1) begin err_cnt++; $display("FAIL steady_led_en p%0d: got dropout need 1", i); end
                end
            end
        end
    endtask

    task automatic test_prescale();
        bit ok;
        win_t o;
        exp_t e;
        prescale = 8'd3;
        cfg_write(1, 255, 1);
        sync_period();
        push_exp(256, 1020, 0, 1024, 1'b1);
        push_exp(256, 1020, 0, 1024, 1'b1);
        for (int i = 0; i < 2; i++) begin
            wait_obs(ok);
            check_cnt++;
            if (!ok) begin err_cnt++; $display("FAIL prescale_timeout: no period %0d", i); end
            else begin
                o = obs_q.pop_front();
                e = exp_q.pop_front();
                for (int c = 0; c < 3; c++) begin
                    check_cnt++;
                    if (o.hi[c] !== e.hi[c]) begin err_cnt++; $display("FAIL prescale_hi ch%0d p%0d: got %0d need %0d", c, i, o.hi[c], e.hi[c]); end
                end
                check_cnt++;
                if (o.len !== e.len) begin err_cnt++; $display("FAIL prescale_len p%0d: got %0d need %0d", i, o.len, e.len); end
                check_cnt++;
                if (o.led_all !== 1'b1) begin err_cnt++; $display("FAIL prescale_led_en p%0d: got dropout need 1", i); end
            end
        end
    endtask

    // Prescale lowered from 15 to 2 while the prescaler sits at 11.
    task automatic test_prescale_drop();
        bit ok;
        win_t o;
        exp_t e;
        prescale = 8'd15;
        sync_period();
        repeat (10) @(posedge clk);
        #1;
        prescale = 8'd2;
        push_exp(204, 777, 0, 780, 1'b1);
        wait_obs(ok);
        check_cnt++;
        if (!ok) begin err_cnt++; $display("FAIL drop_timeout: no period"); end
        else begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            for (int c = 0; c < 3; c++) begin
                check_cnt++;
                if (o.hi[c] !== e.hi[c]) begin err_cnt++; $display("FAIL drop_hi ch%0d: got %0d need %0d", c, o.hi[c], e.hi[c]); end
            end
            check_cnt++;
            if (o.len !== e.len) begin err_cnt++; $display("FAIL drop_len: got %0d need %0d", o.len, e.len); end
        end
    endtask

    task automatic test_bypass();
        bit ok;
        win_t o;
        exp_t e;
        prescale = 8'd0;
        cfg_write(2, 200, 1);
        sync_period();
        cfg_write(2, 128, 1);
        repeat (253) @(posedge clk);
        cfg_write(2, 32, 1);
        push_exp(64, 255, 200, 256, 1'b1);
        push_exp(64, 255, 32, 256, 1'b1);
        push_exp(64, 255, 32, 256, 1'b1);
        for (int i = 0; i < 3; i++) begin
            wait_obs(ok);
            check_cnt++;
            if (!ok) begin err_cnt++; $display("FAIL bypass_timeout: no period %0d", i); end
            else begin
                o = obs_q.pop_front();
                e = exp_q.pop_front();
                for (int c = 0; c < 3; c++) begin
                    check_cnt++;
                    if (o.hi[c] !== e.hi[c]) begin err_cnt++; $display("FAIL bypass_hi ch%0d p%0d: got %0d need %0d", c, i, o.hi[c], e.hi[c]); end
                end
                check_cnt++;
                if (o.len !== e.len) begin err_cnt++; $display("FAIL bypass_len p%0d: got %0d need %0d", i, o.len, e.len); end
            end
        end
    endtask

    task automatic test_blink();
        bit ok;
        win_t o;
        exp_t e;
        int seq[7] = '{255, 0, 0, 255, 255, 0, 0};
        prescale = 8'd0;
        blink_half = 8'd1;
        apply_reset();
        cfg_write(0, 255, 2);
        sync_period();
        for (int i = 0; i < 7; i++) push_exp(seq[i], 0, 0, 256, (i != 0));
        for (int i = 0; i < 7; i++) begin
            wait_obs(ok);
            check_cnt++;
            if (!ok) begin err_cnt++; $display("FAIL blink_timeout: no period %0d", i); end
            else begin
                o = obs_q.pop_front();
                e = exp_q.pop_front();
                for (int c = 0; c < 3; c++) begin
                    check_cnt++;
                    if (o.hi[c] !== e.hi[c]) begin err_cnt++; $display("FAIL blink_hi ch%0d p%0d: got %0d need %0d", c, i, o.hi[c], e.hi[c]); end
                end
                if (e.chk_led) begin
                    check_cnt++;
                    if (o.led_all !== 1'b1) begin err_cnt++; $display("FAIL blink_led_en p%0d: got dropout need 1", i); end
                end
            end
        end
    endtask

    task automatic test_breathe();
        bit ok;
        win_t o;
        exp_t e;
        int seq[17] = '{1, 2, 3, 4, 3, 2, 1, 0, 1, 2, 3, 2, 1, 0, 1, 2, 1};
        cfg_write(0, 4, 3);
        sync_period();
        for (int i = 0; i < 17; i++) push_exp(seq[i], 0, 0, 256, 1'b0);
        for (int i = 0; i < 17; i++) begin
            wait_obs(ok);
            check_cnt++;
            if (!ok) begin err_cnt++; $display("FAIL breathe_timeout: no period %0d", i); end
            else begin
                o = obs_q.pop_front();
                e = exp_q.pop_front();
                check_cnt++;
                if (o.hi[0] !== e.hi[0]) begin err_cnt++; $display("FAIL breathe_ramp p%0d: got %0d need %0d", i, o.hi[0], e.hi[0]); end
                check_cnt++;
                if (o.len !== e.len) begin err_cnt++; $display("FAIL breathe_len p%0d: got %0d need %0d", i, o.len, e.len); end
                // now inside the period whose ramp is 3: lower duty to 2
                if (i == 9) cfg_write(0, 2, 3);
            end
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        win_t o;
        exp_t e;
        int k;
        cfg_write(1, 100, 1);
        cfg_write(2, 80, 1);
        sync_period();
        repeat (40) @(posedge clk);
        #1;
        check_cnt++;
        if (pwm_out[2:1] !== 2'b11) begin err_cnt++; $display("FAIL rmid_pre: got %b need 11", pwm_out[2:1]); end
        apply_reset();
        check_cnt++;
        if (pwm_out !== 3'b000) begin err_cnt++; $display("FAIL rmid_pwm: got %b need 000", pwm_out); end
        check_cnt++;
        if (led_en !== 1'b0) begin err_cnt++; $display("FAIL rmid_led_en: got %b need 0", led_en); end
        check_cnt++;
        if (period_start !== 1'b0) begin err_cnt++; $display("FAIL rmid_period_start: got %b need 0", period_start); end
        k = 0;
        while (k < 2000) begin
            @(posedge clk);
            #1;
            k++;
            if (k == 3) begin
                cfg_we = 1'b1; cfg_ch = 2'd3; cfg_duty = 8'd200; cfg_mode = 2'd1;
            end
            if (k == 4) cfg_we = 1'b0;
            if (period_start === 1'b1) break;
        end
        check_cnt++;
        if (k != 256) begin err_cnt++; $display("FAIL rmid_first_wrap: got %0d cycles need 256", k); end
        sync_period();
        push_exp(0, 0, 0, 256, 1'b0);
        push_exp(0, 0, 0, 256, 1'b0);
        for (int i = 0; i < 2; i++) begin
            wait_obs(ok);
            check_cnt++;
            if (!ok) begin err_cnt++; $display("FAIL rmid_timeout: no period %0d", i); end
            else begin
                o = obs_q.pop_front();
                e = exp_q.pop_front();
                for (int c = 0; c < 3; c++) begin
                    check_cnt++;
                    if (o.hi[c] !== e.hi[c]) begin err_cnt++; $display("FAIL rmid_hi ch%0d p%0d: got %0d need %0d", c, i, o.hi[c], e.hi[c]); end
                end
                check_cnt++;
                if (o.led_any !== 1'b0) begin err_cnt++; $display("FAIL rmid_led_en p%0d: got high need 0", i); end
                check_cnt++;
                if (o.len !== e.len) begin err_cnt++; $display("FAIL rmid_len p%0d: got %0d need %0d", i, o.len, e.len); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_steady();
        test_prescale();
        test_prescale_drop();
        test_bypass();
        test_blink();
        test_breathe();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", check_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/rgb_pwm.md
RGB_PWM -- requirements
Module: rgb_pwm

Interface
REQ-001 Parameter NUM_CH, default 3, number of PWM channels (one per LED colour).
REQ-002 Parameter PWM_WIDTH, default 8, PWM counter and duty width; period = 2^PWM_WIDTH ticks.
REQ-003 Parameter PRESCALE_WIDTH, default 8, width of the tick prescaler.
REQ-004 Parameter BLINK_WIDTH, default 8, width of the blink half-phase counter.
REQ-005 clk  input  1  single clock; all logic on rising edge.
REQ-006 reset_n  input  1  synchronous, active-low reset.
REQ-007 prescale  input  PRESCALE_WIDTH  tick every prescale+1 clk cycles.
REQ-008 cfg_we  input  1  one-cycle configuration write strobe.
REQ-009 cfg_ch  input  max(1,clog2(NUM_CH))  channel index of the write.
REQ-010 cfg_duty  input  PWM_WIDTH  duty value written.
REQ-011 cfg_mode  input  2  mode written: 0 off, 1 steady, 2 blink, 3 breathe.
REQ-012 blink_half  input  BLINK_WIDTH  blink half-phase length = blink_half+1 PWM periods.
REQ-013 pwm_out  output  NUM_CH  registered per-channel PWM, drives the RGBnPWM pins of the LED driver.
REQ-014 led_en  output  1  registered; high when any active channel mode is not off; drives RGBLEDEN and CURREN.
REQ-015 period_start  output  1  one-clk pulse at PWM counter wrap.

Function
REQ-016 Prescaler counts 0..prescale; tick asserted in the cycle it equals prescale, then it returns to 0; prescale=0 gives a tick every cycle.
REQ-017 If prescale drops below the current prescaler count, the prescaler SHALL return to 0 on the next cycle (no count-through).
REQ-018 PWM counter increments on tick, wrapping from 2^PWM_WIDTH-1 to 0; wrap = tick while counter is at maximum.
REQ-019 period_start SHALL be high exactly in the cycle after wrap (registered).
REQ-020 cfg_we with cfg_ch < NUM_CH updates that channel's pending duty/mode; cfg_ch >= NUM_CH is ignored.
REQ-021 Pending duty/mode copy to active registers on wrap only, so no mid-period glitch.
REQ-022 cfg_we coincident with wrap: the written values go directly to the active registers for that channel (bypass); other channels take their pending values.
REQ-023 pwm_out[i] = 1 when mode allows and counter < effective duty, registered one cycle after the counter value.
REQ-024 Effective duty 0 means always low; maximum duty means high for 2^PWM_WIDTH-1 of 2^PWM_WIDTH ticks.
REQ-025 Mode 0: pwm_out[i] low. Mode 1: effective duty = active duty.
REQ-026 Mode 2: shared blink phase; on-phase as mode 1, off-phase low; blink counter counts wraps, phase toggles and counter clears when count = blink_half at a wrap.
REQ-027 Mode 3: per-channel ramp and direction; each wrap ramp steps +1 (up) or -1 (down); direction flips to down on reaching active duty and to up on reaching 0; effective duty = ramp.
REQ-028 Mode 3: if active duty falls below ramp, ramp SHALL clamp to duty at that wrap, with direction set down; active duty 0 holds ramp at 0.
REQ-029 Leaving mode 3 clears that channel's ramp to 0 and direction to up at the same wrap.

Reset
REQ-030 reset_n low at a clk edge clears prescaler, PWM counter, blink counter, all pending/active duty and mode, ramps, and outputs; blink phase resets to on, direction to up.
REQ-031 After reset: pwm_out=0, led_en=0, period_start=0; reset mid-period aborts the period, and the first wrap comes 2^PWM_WIDTH ticks after release.

Structure
REQ-032 Shared package rgb_pwm_pkg holds mode encodings (MODE_OFF, MODE_STEADY, MODE_BLINK, MODE_BREATHE) and the 2-bit mode type.
REQ-033 Sub-module rgb_pwm_ch: pending/active registers, breathe ramp, compare, output flop; generate-instantiated NUM_CH times. Top holds prescaler, PWM counter, blink counter, led_en and period_start.

Verification
REQ-034 prescale=0, ch0 steady duty 64 -> pwm_out[0] high 64 of every 256 clk, period_start every 256 clk.
REQ-035 prescale=3, ch1 duty 255 -> pwm_out[1] high 1020 clk, low 4 clk per 1024-clk period.
REQ-036 ch2 duty 128 written mid-period, then duty 32 written in the wrap cycle -> current period uses old duty, next period high 32 ticks.
REQ-037 ch0 blink, duty 255, blink_half=1 -> 2 periods on, 2 off, repeating; led_en stays 1.
REQ-038 ch0 breathe duty 4 -> effective duty sequence 1,2,3,4,3,2,1,0,1,... per period; duty lowered to 2 at ramp 3 -> ramp 2, then down.
REQ-039 reset_n low 1 cycle mid-period with channels active -> next cycle all outputs 0, cfg writes to cfg_ch=3 ignored.
